// File: rtl/switch_debounce_pkg.sv
// Shared constants and helpers for the switch debouncer.
// Optional feature macro: SWITCH_DEBOUNCE_IRQ_EN (edge capture + interrupt registers).
package switch_debounce_pkg;

  localparam int unsigned DefWidth       = 18;
  localparam int unsigned DefSyncStages  = 2;
  localparam int unsigned DefTickCycles  = 50000;  // 1 ms at 50 MHz
  localparam int unsigned DefStableTicks = 10;     // 10 ms debounce

  // Ceiling log2; returns 0 for value <= 1.
  function automatic int unsigned clog2(input int unsigned value);
    int unsigned r;
    r = 0;
    while ((64'd1 << r) < 64'(value)) r++;
    return r;
  endfunction

endpackage

// File: rtl/sw_debounce_bit.sv
// One switch bit: synchroniser, stability counter, clean level and edge pulses.
module sw_debounce_bit
  import switch_debounce_pkg::*;
#(
  parameter int unsigned SYNC_STAGES  = DefSyncStages,
  parameter int unsigned STABLE_TICKS = DefStableTicks
) (
  input  logic clk,
  input  logic reset_n,
  input  logic tick,
  input  logic sw_raw,
  output logic sw_clean,
  output logic sw_rise,
  output logic sw_fall
);

  localparam int unsigned CntW = clog2(STABLE_TICKS + 1);
  localparam logic [CntW-1:0] CntLast = CntW'(STABLE_TICKS - 1);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   sync;
  logic [CntW-1:0]        cnt_q, cnt_d;
  logic                   clean_q, clean_d;
  logic                   rise_q, rise_d;
  logic                   fall_q, fall_d;

  assign sync = sync_q[SYNC_STAGES-1];

  // Synchroniser chain; the only place the raw pin is sampled.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sync_q <= '0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], sw_raw};
    end
  end

  // Count consecutive differing samples on ticks; any matching sample restarts the count.
  always_comb begin
    cnt_d   = cnt_q;
    clean_d = clean_q;
    rise_d  = 1'b0;
    fall_d  = 1'b0;
    if (tick) begin
      if (sync != clean_q) begin
        if (cnt_q == CntLast) begin
          clean_d = sync;
          cnt_d   = '0;
          rise_d  = sync;
          fall_d  = ~sync;
        end else begin
          cnt_d = cnt_q + CntW'(1);
        end
      end else begin
        cnt_d = '0;
      end
    end
  end

  // Counter, clean level and one-cycle pulse registers.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt_q   <= '0;
      clean_q <= 1'b0;
      rise_q  <= 1'b0;
      fall_q  <= 1'b0;
    end else begin
      cnt_q   <= cnt_d;
      clean_q <= clean_d;
      rise_q  <= rise_d;
      fall_q  <= fall_d;
    end
  end

  assign sw_clean = clean_q;
  assign sw_rise  = rise_q;
  assign sw_fall  = fall_q;

endmodule

// File: rtl/switch_debouncer.sv
// Slide-switch conditioner: shared sample-tick prescaler feeding per-bit debouncers.
// Define SWITCH_DEBOUNCE_IRQ_EN to add edge capture registers and a masked interrupt.
module switch_debouncer
  import switch_debounce_pkg::*;
#(
  parameter int unsigned WIDTH        = DefWidth,
  parameter int unsigned SYNC_STAGES  = DefSyncStages,
  parameter int unsigned TICK_CYCLES  = DefTickCycles,
  parameter int unsigned STABLE_TICKS = DefStableTicks
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [WIDTH-1:0] sw_raw,
  output logic [WIDTH-1:0] sw_clean,
  output logic [WIDTH-1:0] sw_rise,
`ifdef SWITCH_DEBOUNCE_IRQ_EN
  output logic [WIDTH-1:0] sw_fall,
  input  logic [WIDTH-1:0] edge_clear,
  input  logic [WIDTH-1:0] irq_mask,
  output logic [WIDTH-1:0] edge_capture,
  output logic             irq
`else
  output logic [WIDTH-1:0] sw_fall
`endif
);

  // A single-cycle tick period still needs a 1-bit register.
  localparam int unsigned PrescW = (TICK_CYCLES > 1) ? clog2(TICK_CYCLES) : 1;
  localparam logic [PrescW-1:0] PrescLast = PrescW'(TICK_CYCLES - 1);

  logic [PrescW-1:0] presc_q, presc_d;
  logic              tick;

  // Prescaler next state: wrap on the last count, which is also the tick cycle.
  always_comb begin
    tick    = (presc_q == PrescLast);
    presc_d = tick ? '0 : presc_q + PrescW'(1);
  end

  // Prescaler register.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      presc_q <= '0;
    end else begin
      presc_q <= presc_d;
    end
  end

  for (genvar i = 0; i < WIDTH; i++) begin : g_bit
    sw_debounce_bit #(
      .SYNC_STAGES  (SYNC_STAGES),
      .STABLE_TICKS (STABLE_TICKS)
    ) u_bit (
      .clk      (clk),
      .reset_n  (reset_n),
      .tick     (tick),
      .sw_raw   (sw_raw[i]),
      .sw_clean (sw_clean[i]),
      .sw_rise  (sw_rise[i]),
      .sw_fall  (sw_fall[i])
    );
  end

`ifdef SWITCH_DEBOUNCE_IRQ_EN
  logic [WIDTH-1:0] capture_q, capture_d;

  // Set has priority over write-1-to-clear so an edge is never lost.
  always_comb begin
    capture_d = (capture_q & ~edge_clear) | sw_rise | sw_fall;
  end

  // Edge capture register.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      capture_q <= '0;
    end else begin
      capture_q <= capture_d;
    end
  end

  assign edge_capture = capture_q;
  assign irq          = |(capture_q & irq_mask);
`endif

endmodule
